// File: rtl/decimal_entry.sv
// -----------------------------------------------------------------------------
// decimal_entry
//   Collects up to MAX_DIGITS decimal digits from switches and push-buttons
//   into an 8-bit binary value. Enter commits the value and holds it
//   (Valid=1) until the consumer acknowledges it. Clear discards the entry.
//
//   Optional build macro: DEBOUNCE_EN adds a per-button stability filter of
//   DEBOUNCE_CYCLES samples after the synchronizers.
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous, active-high
//   Digit[3:0]  BCD digit from the switches
//   Push        raw button: append Digit
//   Enter       raw button: commit the entry
//   Clear       raw button: discard the entry
//   Ack         consumer acknowledge, level-sampled
//   Value[7:0]  binary value of the entry
//   Valid       committed Value available
//   Overflow    sticky: a digit was rejected because the value would pass 255
//   DigitCount  number of accepted digits
//   Units/Tens/Hundreds  BCD echo of the accepted digits
//   Leds[3:0]   {Overflow, state lamps}: 001 idle, 011 entry, 111 hold
// -----------------------------------------------------------------------------
module decimal_entry #(
  parameter int MAX_DIGITS      = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] Digit,
  input  logic       Push,
  input  logic       Enter,
  input  logic       Clear,
  input  logic       Ack,
  output logic [7:0] Value,
  output logic       Valid,
  output logic       Overflow,
  output logic [1:0] DigitCount,
  output logic [3:0] Units,
  output logic [3:0] Tens,
  output logic [3:0] Hundreds,
  output logic [3:0] Leds
);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_HOLD} state_t;

  localparam logic [1:0] MAX_CNT = MAX_DIGITS[1:0];

  // Button vector: bit 0 = Push, bit 1 = Enter, bit 2 = Clear.
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0] arm_q, arm_d;
  logic [1:0] ready_q, ready_d;
  logic [2:0] level;
  logic [2:0] ev;

  state_t     state_q, state_d;
  logic [7:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;
  logic [1:0] count_q, count_d;
  logic [3:0] units_q, units_d, tens_q, tens_d, hundreds_q, hundreds_d;
  logic [3:0] leds_q, leds_d;
  logic [9:0] next_val;

`ifdef DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]      level_q, level_d;
  logic [DB_W-1:0] cnt_q [3];
  logic [DB_W-1:0] cnt_d [3];

  // The filtered level follows the synchronized button only after
  // DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) level_d[i] = sync2_q[i];
        else                      cnt_d[i]   = cnt_q[i] + 1'b1;
      end
    end
  end

  assign level = level_q;
`else
  // Keeps the debounce parameter referenced when the filter is compiled out.
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);

  assign level = sync2_q;
`endif

  // A button only fires after it has been seen low (arm set). ready_q keeps
  // arming off until the synchronizers have refilled after reset, so a button
  // held through reset never looks like a fresh press.
  assign ev = level & arm_q;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sync1_d = {Clear, Enter, Push};
    sync2_d = sync1_q;
    ready_d = {ready_q[0], 1'b1};
    arm_d   = (arm_q | ({3{ready_q[1]}} & ~level & ~sync2_q)) & ~ev;
  end

  // Entry FSM and datapath; priority Clear > Ack (hold) > Enter > Push.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    units_d    = units_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    // At most two digits precede an accepted push, so value*10+9 <= 999.
    next_val   = {2'b00, value_q} * 10'd10 + {6'd0, Digit};

    if (ev[2] || (state_q == S_HOLD && Ack)) begin
      state_d    = S_IDLE;
      value_d    = '0;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
      count_d    = '0;
      units_d    = '0;
      tens_d     = '0;
      hundreds_d = '0;
    end else if (ev[1] && state_q == S_ENTRY) begin
      state_d = S_HOLD;
      valid_d = 1'b1;
    end else if (ev[0] && state_q != S_HOLD && Digit <= 4'd9 && count_q < MAX_CNT) begin
      if (next_val <= 10'd255) begin
        state_d    = S_ENTRY;
        value_d    = next_val[7:0];
        count_d    = count_q + 1'b1;
        hundreds_d = tens_q;
        tens_d     = units_q;
        units_d    = Digit;
      end else begin
        overflow_d = 1'b1;
      end
    end

    case (state_d)
      S_ENTRY: leds_d = {overflow_d, 3'b011};
      S_HOLD:  leds_d = {overflow_d, 3'b111};
      default: leds_d = {overflow_d, 3'b001};
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      arm_q      <= '0;
      ready_q    <= '0;
      state_q    <= S_IDLE;
      value_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      units_q    <= '0;
      tens_q     <= '0;
      hundreds_q <= '0;
      leds_q     <= 4'b0001;
`ifdef DEBOUNCE_EN
      level_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      arm_q      <= arm_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
      leds_q     <= leds_d;
`ifdef DEBOUNCE_EN
      level_q    <= level_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
`endif
    end
  end

  assign Value      = value_q;
  assign Valid      = valid_q;
  assign Overflow   = overflow_q;
  assign DigitCount = count_q;
  assign Units      = units_q;
  assign Tens       = tens_q;
  assign Hundreds   = hundreds_q;
  assign Leds       = leds_q;

endmodule
